nonce_scheduler: RTL and testbench
==================================

Name: nonce_scheduler

Overview:
Sequences the hash/compare datapath for one mining job. Accepts a job (nonce range plus 64-bit target), issues one nonce per cycle into the hash pipeline, and buffers nonces reported by the compare stage in a small result FIFO. Drains the pipeline before signalling completion, and supports abort.

Parameters:
PIPE_DEPTH, 8, cycles from a hash_valid issue to the corresponding compare found/busy result; range 1..255
FIFO_DEPTH, 4, result FIFO entries; power of two, minimum 2

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
job_valid  in  1  job offered
job_ready  out  1  scheduler can accept a job
job_start  in  32  first nonce, inclusive
job_end  in  32  last nonce, inclusive
job_target  in  64  hash target for the job
abort  in  1  stop issuing the current job
hash_stall  in  1  pipeline cannot accept an issue this cycle
hash_valid  out  1  nonce issued to the hash pipeline this cycle
hash_nonce  out  32  nonce being issued
hash_target  out  64  latched job target, held for the compare stage
found  in  1  compare stage result: hash below target
found_nonce  in  32  nonce associated with found
res_valid  out  1  result FIFO not empty
res_ready  in  1  consumer pops the head entry
res_nonce  out  32  FIFO head nonce
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse at job completion
done_aborted  out  1  valid with done: the job ended by abort
overflow  out  1  sticky: a found result was dropped

Behaviour:
- Reset (asynchronous assert, synchronous release) sets: state IDLE, job_ready=1, hash_valid=0, hash_nonce=0, hash_target=0, res_valid=0, busy=0, done=0, done_aborted=0, overflow=0, FIFO empty.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - job_ready=1.
  - A job is accepted on an edge where job_valid=1. At that edge: latch start, end and target; clear overflow; next state ISSUE.
- ISSUE:
  - hash_valid = !hash_stall (combinational). hash_nonce = cur, registered.
  - On an edge where hash_valid=1 and cur!=end: cur <= cur+1, wrapping modulo 2^32.
  - On an edge where hash_valid=1 and cur==end: next state DRAIN.
  - On a stalled edge cur holds.
  - First hash_valid appears in the cycle after acceptance, with nonce = job_start.
  - Range semantics:
    - start==end: issues exactly one nonce.
    - end<start: wraps through 0xFFFFFFFF to 0.
- abort:
  - Sampled at each edge in ISSUE.
  - If asserted, nothing further is issued: hash_valid is forced to 0 in the cycle abort is high. Next state DRAIN, aborted flag set.
  - Ignored in IDLE and DRAIN.
- DRAIN:
  - hash_valid=0.
  - Down-counter loads PIPE_DEPTH-1 on entry and decrements each cycle.
  - When the counter reaches 0: done=1 for one cycle, done_aborted=aborted flag, next state IDLE.
  - DRAIN therefore lasts PIPE_DEPTH cycles.
- hash_target holds the latched target from acceptance until the next job is accepted.
- Result FIFO:
  - A push occurs on any edge with found=1, in any state including IDLE.
  - A pop occurs on an edge with res_valid & res_ready.
  - res_nonce is the head entry, first-word fall-through.
  - Simultaneous push and pop:
    - When full: both succeed and the count is unchanged.
    - When empty: the push succeeds and res_valid rises the next cycle.
  - Push when full without a pop: the entry is dropped and overflow is set to 1. overflow stays set until the next job acceptance or reset.
- A new job cannot be accepted in the same cycle as done. job_ready rises the cycle after done.
- busy=1 in ISSUE and DRAIN.

Test Plan:
- Basic range: reset, then job start=0x10, end=0x13, no stall -> hash_valid for 4 consecutive cycles with nonces 0x10..0x13; DRAIN then lasts PIPE_DEPTH cycles; done=1 with done_aborted=0; busy falls together with done's removal.
- Stall and single nonce: job start=end=0x5, hash_stall high for 3 cycles after acceptance -> no issue during the stall; exactly one hash_valid with nonce 0x5 after the stall releases.
- Wrap: job start=0xFFFFFFFE, end=0x1 -> nonces issued in order 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1, then DRAIN.
- Abort: job 0x0..0xFF; abort asserted on the 3rd issue cycle -> only nonces 0x0 and 0x1 issued; DRAIN lasts PIPE_DEPTH cycles; done=1 with done_aborted=1.
- FIFO: res_ready=0 while FIFO_DEPTH+1 found pulses arrive (nonces 0xA0..0xA4) -> FIFO holds 0xA0..0xA3 and overflow=1; after draining with res_ready=1, entries pop in order; a simultaneous push and pop when full keeps the count at FIFO_DEPTH.
- Reset mid-job: deassert rst_n during ISSUE with FIFO non-empty -> all outputs return to reset values immediately, FIFO empty, job_ready=1 after release.

Source files
------------

// File: rtl/nonce_scheduler.sv
// Mining-job sequencer: issues one nonce per cycle into the hash pipeline,
// drains the pipeline before reporting done, and buffers found nonces in a FIFO.
module nonce_scheduler #(
  parameter int unsigned PIPE_DEPTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_start,
  input  logic [31:0] job_end,
  input  logic [63:0] job_target,
  input  logic        abort,
  input  logic        hash_stall,
  output logic        hash_valid,
  output logic [31:0] hash_nonce,
  output logic [63:0] hash_target,
  input  logic        found,
  input  logic [31:0] found_nonce,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_nonce,
  output logic        busy,
  output logic        done,
  output logic        done_aborted,
  output logic        overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [7:0]  DRAIN_LOAD = 8'(PIPE_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] cur_q, cur_d;
  logic [31:0] end_q, end_d;
  logic [63:0] target_q, target_d;
  logic [7:0]  drain_q, drain_d;
  logic        aborted_q, aborted_d;
  logic        overflow_q, overflow_d;
  logic [31:0] mem_q [FIFO_DEPTH];
  logic [31:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic ovf_clr;
  logic fifo_full;
  logic push, pop, drop;

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    end_d      = end_q;
    target_d   = target_q;
    drain_d    = drain_q;
    aborted_d  = aborted_q;
    ovf_clr    = 1'b0;
    job_ready  = 1'b0;
    hash_valid = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          cur_d     = job_start;
          end_d     = job_end;
          target_d  = job_target;
          aborted_d = 1'b0;
          ovf_clr   = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          aborted_d = 1'b1;
          drain_d   = DRAIN_LOAD;
          state_d   = S_DRAIN;
        end else if (!hash_stall) begin
          hash_valid = 1'b1;
          if (cur_q == end_q) begin
            drain_d = DRAIN_LOAD;
            state_d = S_DRAIN;
          end else begin
            cur_d = cur_q + 32'd1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == 8'd0) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          drain_d = drain_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop frees the head slot in the same edge, so a push while full still lands.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    fifo_full = (count_q == CW'(FIFO_DEPTH));
    pop       = (count_q != '0) && res_ready;
    push      = found && (!fifo_full || pop);
    drop      = found && fifo_full && !pop;

    if (push) begin
      mem_d[wr_ptr_q] = found_nonce;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // A drop on the accepting edge still marks overflow for the new job.
    overflow_d = (overflow_q && !ovf_clr) || drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      end_q      <= '0;
      target_q   <= '0;
      drain_q    <= '0;
      aborted_q  <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      end_q      <= end_d;
      target_q   <= target_d;
      drain_q    <= drain_d;
      aborted_q  <= aborted_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  assign hash_nonce   = cur_q;
  assign hash_target  = target_q;
  assign res_valid    = (count_q != '0);
  assign res_nonce    = mem_q[rd_ptr_q];
  assign busy         = (state_q != S_IDLE);
  assign done_aborted = done && aborted_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler: issue sequencing, stall, wrap, abort,
// result FIFO ordering/overflow and asynchronous reset mid-job.
module tb_nonce_scheduler;

  localparam int unsigned PD = 8;
  localparam int unsigned FD = 4;

  logic        clk;
  logic        rst_n;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_start;
  logic [31:0] job_end;
  logic [63:0] job_target;
  logic        abort;
  logic        hash_stall;
  logic        hash_valid;
  logic [31:0] hash_nonce;
  logic [63:0] hash_target;
  logic        found;
  logic [31:0] found_nonce;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_nonce;
  logic        busy;
  logic        done;
  logic        done_aborted;
  logic        overflow;

  int n_checks;
  int n_fail;

  nonce_scheduler #(.PIPE_DEPTH(PD), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_start(job_start), .job_end(job_end), .job_target(job_target),
    .abort(abort), .hash_stall(hash_stall),
    .hash_valid(hash_valid), .hash_nonce(hash_nonce), .hash_target(hash_target),
    .found(found), .found_nonce(found_nonce),
    .res_valid(res_valid), .res_ready(res_ready), .res_nonce(res_nonce),
    .busy(busy), .done(done), .done_aborted(done_aborted), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects to be called in the first DRAIN cycle; leaves the bench in IDLE.
  task automatic drain_check(input logic exp_aborted);
    for (int i = 0; i < int'(PD); i++) begin
      #1;
      chk("drain_hv", hash_valid, 0);
      chk("drain_busy", busy, 1);
      chk("drain_done", done, (i == int'(PD) - 1) ? 1 : 0);
      if (i == int'(PD) - 1) chk("drain_done_aborted", done_aborted, exp_aborted);
      chk("drain_job_ready", job_ready, 0);
      tick();
    end
    chk("post_done_busy", busy, 0);
    chk("post_done_done", done, 0);
    chk("post_done_job_ready", job_ready, 1);
  endtask

  task automatic accept(input logic [31:0] s, input logic [31:0] e, input logic [63:0] t);
    job_valid  = 1'b1;
    job_start  = s;
    job_end    = e;
    job_target = t;
    #1;
    chk("accept_job_ready", job_ready, 1);
    tick();
    job_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] wrap_exp [4];
    logic [31:0] pop_exp [4];
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    job_valid   = 1'b0;
    job_start   = '0;
    job_end     = '0;
    job_target  = '0;
    abort       = 1'b0;
    hash_stall  = 1'b0;
    found       = 1'b0;
    found_nonce = '0;
    res_ready   = 1'b0;

    // Reset state
    #2;
    chk("rst_job_ready", job_ready, 1);
    chk("rst_hash_valid", hash_valid, 0);
    chk("rst_hash_nonce", hash_nonce, 0);
    chk("rst_hash_target", hash_target, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic range 0x10..0x13
    accept(32'h10, 32'h13, 64'h0000_00FF_FFFF_0000);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("basic_hv", hash_valid, 1);
      chk("basic_nonce", hash_nonce, 32'h10 + i);
      chk("basic_busy", busy, 1);
      chk("basic_target", hash_target, 64'h0000_00FF_FFFF_0000);
      tick();
    end
    drain_check(1'b0);
    chk("target_held_idle", hash_target, 64'h0000_00FF_FFFF_0000);

    // Stall then single nonce
    hash_stall = 1'b1;
    accept(32'h5, 32'h5, 64'h1234);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_hv", hash_valid, 0);
      chk("stall_nonce", hash_nonce, 32'h5);
      tick();
    end
    hash_stall = 1'b0;
    #1;
    chk("single_hv", hash_valid, 1);
    chk("single_nonce", hash_nonce, 32'h5);
    tick();
    drain_check(1'b0);

    // Wrap through 0xFFFFFFFF
    wrap_exp[0] = 32'hFFFF_FFFE;
    wrap_exp[1] = 32'hFFFF_FFFF;
    wrap_exp[2] = 32'h0;
    wrap_exp[3] = 32'h1;
    accept(32'hFFFF_FFFE, 32'h1, 64'h55);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wrap_hv", hash_valid, 1);
      chk("wrap_nonce", hash_nonce, wrap_exp[i]);
      tick();
    end
    drain_check(1'b0);

    // Abort on the third issue cycle
    accept(32'h0, 32'hFF, 64'h77);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("abort_pre_hv", hash_valid, 1);
      chk("abort_pre_nonce", hash_nonce, i);
      tick();
    end
    abort = 1'b1;
    #1;
    chk("abort_hv_forced", hash_valid, 0);
    tick();
    abort = 1'b0;
    drain_check(1'b1);

    // FIFO fill + overflow
    for (int i = 0; i < int'(FD) + 1; i++) begin
      found       = 1'b1;
      found_nonce = 32'hA0 + i;
      tick();
      found = 1'b0;
      #1;
      chk("fill_overflow", overflow, (i == int'(FD)) ? 1 : 0);
    end
    chk("full_res_valid", res_valid, 1);
    chk("full_head", res_nonce, 32'hA0);
    // Push and pop together while full: both happen
    found       = 1'b1;
    found_nonce = 32'hB0;
    res_ready   = 1'b1;
    tick();
    found = 1'b0;
    pop_exp[0] = 32'hA1;
    pop_exp[1] = 32'hA2;
    pop_exp[2] = 32'hA3;
    pop_exp[3] = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("pop_valid", res_valid, 1);
      chk("pop_nonce", res_nonce, pop_exp[i]);
      tick();
    end
    #1;
    chk("fifo_empty", res_valid, 0);
    // Push and pop together while empty: push wins
    found       = 1'b1;
    found_nonce = 32'hD0;
    tick();
    found     = 1'b0;
    res_ready = 1'b0;
    #1;
    chk("empty_push_valid", res_valid, 1);
    chk("empty_push_nonce", res_nonce, 32'hD0);
    chk("overflow_sticky", overflow, 1);

    // Reset mid-job with FIFO non-empty; acceptance clears overflow
    accept(32'h100, 32'h1FF, 64'hDEAD_BEEF);
    tick();
    #1;
    chk("mid_overflow_cleared", overflow, 0);
    chk("mid_hv", hash_valid, 1);
    chk("mid_nonce", hash_nonce, 32'h101);
    chk("mid_res_valid", res_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_hash_valid", hash_valid, 0);
    chk("mrst_hash_nonce", hash_nonce, 0);
    chk("mrst_hash_target", hash_target, 0);
    chk("mrst_res_valid", res_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_job_ready", job_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("release_job_ready", job_ready, 1);
    chk("release_res_valid", res_valid, 0);
    chk("release_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
